modsub_invmult_pipe: RTL and testbench

- Parametrised successor to the fixed 18-bit subtract/inverse-multiply digit stage used in RNS mixed-radix conversion.
- Computes ((A op B) mod MODULUS), optionally scaled by a modular inverse, per transaction.
- Adds a valid/ready handshake with full-pipeline stall, per-transaction op mode, a tag passthrough and an out-of-range flag.
- Sits between residue-digit register files and the MRC accumulator in the TPU datapath.

---
 rtl/modsub_invmult_pipe.sv | 192 +++++++++++++++++++
 tb/tb_modsub_invmult_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modsub_invmult_pipe.sv
// -----------------------------------------------------------------------------
// modsub_invmult_pipe
//   One digit stage of RNS mixed-radix conversion. Per transaction it computes
//   (A - B) or (A + B) modulo MODULUS, optionally scaled by the constant
//   modular inverse INV. It is a fixed-depth pipeline of LATENCY register
//   stages, and one valid/ready enable stalls the whole pipeline.
//
//   Stage 1 : range check, sub/add and both correction candidates in parallel
//   Stage 2 : candidate select from the registered sign / compare bit
//   Stage 3 : constant-INV scaling (weighted bit sum + conditional subtracts),
//             range-error zeroing, bypass for the unscaled modes
//   Stage 4..LATENCY : delay registers, so every mode has the same latency
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; in_ready = global advance
//   in_a, in_b              residues
//   in_mode                 0:(A-B)*INV  1:A-B  2:A+B  3:(A+B)*INV  (all mod M)
//   in_tag                  sideband, returned unchanged with the result
//   out_valid / out_ready   result handshake
//   out_data                result in [0, M-1]; 0 on a range error
//   out_tag                 tag of this result
//   out_range_err           in_a >= M or in_b >= M for this transaction
// -----------------------------------------------------------------------------
module modsub_invmult_pipe #(
  parameter int          DATA_WIDTH = 18,
  parameter int unsigned MODULUS    = 78125,
  parameter int unsigned INV        = 1,
  parameter int          TAG_WIDTH  = 8,
  parameter int          LATENCY    = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [1:0]            in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_range_err
);

  localparam int DW = DATA_WIDTH;
  // The weighted bit sum has at most 32 terms below M, so it stays under 32*M.
  localparam int AW = DW + 6;
  localparam logic [DW:0] M_EXT = (DW+1)'(MODULUS);

  typedef enum logic [1:0] {
    MODE_SUB_SCALE = 2'd0,
    MODE_SUB       = 2'd1,
    MODE_ADD       = 2'd2,
    MODE_ADD_SCALE = 2'd3
  } mode_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
    logic                 scale;
    logic                 is_add;
    logic                 neg;    // A - B went negative
    logic [DW-1:0]        d;
    logic [DW-1:0]        d_fix;  // A - B + M
    logic [DW-1:0]        s;
    logic [DW-1:0]        s_fix;  // A + B - M
    logic                 ge;     // A + B >= M
  } s1_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
    logic                 scale;
    logic [DW-1:0]        v;
  } s2_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
    logic [DW-1:0]        v;
  } st_t;

  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  st_t           t3_d;
  st_t           tail_q [3:LATENCY];
  logic          adv;
  mode_e         mode;
  logic [DW:0]   d_w, s_w;
  logic [AW-1:0] acc;
  logic [DW-1:0] scaled;

  // All stages share one enable, so a full output slot freezes everything
  // behind it. Bubbles keep their slot because the whole pipeline shifts together.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign mode      = mode_e'(in_mode);

  // (INV * 2^i) mod M. Called with a loop constant, so it folds to a constant.
  function automatic logic [DW-1:0] weight(input int i);
    longint unsigned w;
    w = 64'(INV % MODULUS);
    for (int j = 0; j < i; j++) w = (w << 1) % 64'(MODULUS);
    return w[DW-1:0];
  endfunction

  // ---- stage 1: arithmetic with both candidates in parallel ----------------
  // The correction terms are only kept to DW bits. When a correction is
  // selected, the true result lies in [0, M), so arithmetic mod 2^DW is exact.
  assign d_w = {1'b0, in_a} - {1'b0, in_b};
  assign s_w = {1'b0, in_a} + {1'b0, in_b};

  always_comb begin
    s1_d        = '0;
    s1_d.valid  = in_valid;
    s1_d.tag    = in_tag;
    s1_d.err    = ({1'b0, in_a} >= M_EXT) || ({1'b0, in_b} >= M_EXT);
    s1_d.scale  = (mode == MODE_SUB_SCALE) || (mode == MODE_ADD_SCALE);
    s1_d.is_add = (mode == MODE_ADD) || (mode == MODE_ADD_SCALE);
    s1_d.neg    = d_w[DW];
    s1_d.d      = d_w[DW-1:0];
    s1_d.d_fix  = d_w[DW-1:0] + M_EXT[DW-1:0];
    s1_d.s      = s_w[DW-1:0];
    s1_d.s_fix  = s_w[DW-1:0] - M_EXT[DW-1:0];
    s1_d.ge     = (s_w >= M_EXT);
  end

  // ---- stage 2: candidate select -------------------------------------------
  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.tag   = s1_q.tag;
    s2_d.err   = s1_q.err;
    s2_d.scale = s1_q.scale;
    if (s1_q.is_add) s2_d.v = s1_q.ge  ? s1_q.s_fix : s1_q.s;
    else             s2_d.v = s1_q.neg ? s1_q.d_fix : s1_q.d;
  end

  // ---- stage 3: constant-INV scaling ---------------------------------------
  // v*INV mod M = sum of v[i]*((2^i*INV) mod M). The sum is below 32*M.
  // Subtracting 16M, 8M, 4M, 2M and M in turn, each only when it fits,
  // brings the sum into [0, M).
  // NOTE: acc is a combinational scratch variable, so it uses blocking
  // assignments and is re-assigned step by step in one pass. A non-blocking
  // assignment here would read stale values.
  always_comb begin
    acc = '0;
    for (int i = 0; i < DW; i++)
      if (s2_q.v[i]) acc = acc + AW'(weight(i));
    for (int k = 4; k >= 0; k--)
      if (acc >= (AW'(MODULUS) << k)) acc = acc - (AW'(MODULUS) << k);
    scaled = acc[DW-1:0];
  end

  always_comb begin
    t3_d       = '0;
    t3_d.valid = s2_q.valid;
    t3_d.tag   = s2_q.tag;
    t3_d.err   = s2_q.err;
    if (s2_q.err)        t3_d.v = '0;
    else if (s2_q.scale) t3_d.v = scaled;
    else                 t3_d.v = s2_q.v;
  end

  // ---- pipeline registers ---------------------------------------------------
  // NOTE: the datapath fields are reset as well as the valid bits. The output
  // stage must read as all-zero in reset, and clearing every stage keeps the
  // register chain uniform.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      for (int i = 3; i <= LATENCY; i++) tail_q[i] <= '0;
    end else if (adv) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      tail_q[3] <= t3_d;
      for (int i = 4; i <= LATENCY; i++) tail_q[i] <= tail_q[i-1];
    end
  end

  assign out_valid     = tail_q[LATENCY].valid;
  assign out_data      = tail_q[LATENCY].v;
  assign out_tag       = tail_q[LATENCY].tag;
  assign out_range_err = tail_q[LATENCY].err;

endmodule

// File: tb/tb_modsub_invmult_pipe.sv
// -----------------------------------------------------------------------------
// tb_modsub_invmult_pipe
//   Directed and streaming bench for modsub_invmult_pipe (M=78125, INV=3,
//   LATENCY=7). Inputs change 1 ns after a rising edge. A monitor records each
//   output transfer on the falling edge, so the result is captured while it is
//   stable.
// -----------------------------------------------------------------------------
module tb_modsub_invmult_pipe;

  localparam int          DW  = 18;
  localparam int          TW  = 8;
  localparam int unsigned M   = 78125;
  localparam int unsigned INV = 3;
  localparam int          LAT = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_range_err;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          err;
    int            cyc;
  } xact_t;

  xact_t exp_q[$];
  xact_t obs_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc_cnt = 0;

  modsub_invmult_pipe #(
    .DATA_WIDTH(DW), .MODULUS(M), .INV(INV), .TAG_WIDTH(TW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_range_err(out_range_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // A transfer happens at the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      xact_t o;
      o.data = out_data;
      o.tag  = out_tag;
      o.err  = out_range_err;
      o.cyc  = cyc_cnt;
      obs_q.push_back(o);
    end
  end

  // Reference formula.
  function automatic xact_t model(input int unsigned a, input int unsigned b,
                                  input logic [1:0] m, input logic [TW-1:0] t);
    xact_t x;
    longint unsigned r;
    x.tag = t;
    x.cyc = 0;
    x.err = (a >= M) || (b >= M);
    if (x.err) r = 0;
    else begin
      if (m[1]) r = (64'(a) + 64'(b)) % 64'(M);
      else      r = (64'(a) + 64'(M) - 64'(b)) % 64'(M);
      if (m == 2'd0 || m == 2'd3) r = (r * 64'(INV)) % 64'(M);
    end
    x.data = r[DW-1:0];
    return x;
  endfunction

  // Enter 1 ns after an edge. Hold the transaction until it is accepted,
  // then return 1 ns after the accept edge with in_valid still high.
  task automatic send(input int unsigned a, input int unsigned b,
                      input logic [1:0] m, input logic [TW-1:0] t);
    int guard = 0;
    in_valid = 1'b1; in_a = DW'(a); in_b = DW'(b); in_mode = m; in_tag = t;
    #1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #2;
      guard++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int n);
    int guard = 0;
    while (obs_q.size() < n && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(1, 2, 2'd1, 8'h01);
    send(3, 4, 2'd2, 8'h02);
    send(5, 6, 2'd3, 8'h03);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%0d want=0", out_data); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_out_tag got=%0h want=0", out_tag); end
    total++; if (out_range_err !== 1'b0) begin bad++; $display("FAIL rst_range_err got=%b want=0", out_range_err); end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    obs_q.delete();
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL rst_stale got=%0d results want=0", obs_q.size()); end
  endtask

  task automatic test_sub_wrap();
    int  waited;
    bit  seen;
    obs_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 18'd5; in_b = 18'd10; in_mode = 2'd0; in_tag = 8'h2A;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sub_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0; seen = 0;
    while (!seen && waited < 30) begin
      if (out_valid === 1'b1) seen = 1;
      else begin @(posedge clk); #1; waited++; end
    end
    // The result is consumed at the edge after out_valid rises: accept edge + LAT.
    total++; if (waited + 1 !== LAT) begin bad++; $display("FAIL sub_latency got=%0d want=%0d", waited + 1, LAT); end
    total++; if (out_data !== 18'd78110) begin bad++; $display("FAIL sub_data got=%0d want=78110", out_data); end
    total++; if (out_tag !== 8'h2A) begin bad++; $display("FAIL sub_tag got=%0h want=2a", out_tag); end
    total++; if (out_range_err !== 1'b0) begin bad++; $display("FAIL sub_err got=%b want=0", out_range_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    logic [DW-1:0] want [3];
    want[0] = 18'd75; want[1] = 18'd0; want[2] = 18'd225;
    obs_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(78000, 200, 2'd2, 8'hA0);
    send(12345, 12345, 2'd1, 8'hA1);
    send(78000, 200, 2'd3, 8'hA2);
    in_valid = 1'b0;
    wait_drain(3);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL add_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== want[i] || obs_q[i].tag !== 8'(8'hA0 + i) || obs_q[i].err !== 1'b0) begin
        bad++;
        $display("FAIL add_result[%0d] got=%0d/%0h/%b want=%0d/%0h/0", i, obs_q[i].data, obs_q[i].tag,
                 obs_q[i].err, want[i], 8'(8'hA0 + i));
      end
    end
  endtask

  task automatic test_range_err();
    obs_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(78125, 1, 2'd0, 8'h11);
    send(3, 78130, 2'd2, 8'h12);
    send(100, 50, 2'd1, 8'h13);
    in_valid = 1'b0;
    wait_drain(3);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL rng_count got=%0d want=3", obs_q.size()); end
    if (obs_q.size() == 3) begin
      total++;
      if (obs_q[0].err !== 1'b1 || obs_q[0].data !== '0 || obs_q[0].tag !== 8'h11) begin
        bad++; $display("FAIL rng_a got=%b/%0d/%0h want=1/0/11", obs_q[0].err, obs_q[0].data, obs_q[0].tag);
      end
      total++;
      if (obs_q[1].err !== 1'b1 || obs_q[1].data !== '0 || obs_q[1].tag !== 8'h12) begin
        bad++; $display("FAIL rng_b got=%b/%0d/%0h want=1/0/12", obs_q[1].err, obs_q[1].data, obs_q[1].tag);
      end
      total++;
      if (obs_q[2].err !== 1'b0 || obs_q[2].data !== 18'd50 || obs_q[2].tag !== 8'h13) begin
        bad++; $display("FAIL rng_next got=%b/%0d/%0h want=0/50/13", obs_q[2].err, obs_q[2].data, obs_q[2].tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned a, b;
    logic [1:0]  m;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      a = $urandom_range(0, M - 1);
      b = $urandom_range(0, M - 1);
      m = 2'($urandom_range(0, 3));
      exp_q.push_back(model(a, b, m, 8'(i)));
      send(a, b, m, 8'(i));
    end
    in_valid = 1'b0;
    wait_drain(100);
    total++; if (obs_q.size() !== 100) begin bad++; $display("FAIL b2b_count got=%0d want=100", obs_q.size()); end
    for (int i = 0; i < 100 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag || obs_q[i].err !== exp_q[i].err) begin
        bad++;
        $display("FAIL b2b_result[%0d] got=%0d/%0h/%b want=%0d/%0h/%b", i, obs_q[i].data, obs_q[i].tag,
                 obs_q[i].err, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
      total++;
      if (obs_q[i].cyc !== obs_q[0].cyc + i) begin
        bad++; $display("FAIL b2b_gap[%0d] got_cycle=%0d want_cycle=%0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_d;
    logic [TW-1:0] held_t;
    logic [DW-1:0] want [3];
    int            guard;
    want[0] = 18'd93; want[1] = 18'd78032; want[2] = 18'd1875;
    obs_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(100, 7, 2'd1, 8'h41);
    send(7, 100, 2'd1, 8'h42);
    send(40000, 40000, 2'd2, 8'h43);
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    held_d = out_data;
    held_t = out_tag;
    total++; if (held_d !== want[0] || held_t !== 8'h41) begin
      bad++; $display("FAIL bp_first got=%0d/%0h want=93/41", held_d, held_t);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got=v%b d%0d t%0h r%b want=v1 d%0d t%0h r0", c, out_valid, out_data,
                 out_tag, in_ready, held_d, held_t);
      end
    end
    out_ready = 1'b1;
    wait_drain(3);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL bp_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== want[i] || obs_q[i].tag !== 8'(8'h41 + i)) begin
        bad++;
        $display("FAIL bp_result[%0d] got=%0d/%0h want=%0d/%0h", i, obs_q[i].data, obs_q[i].tag, want[i],
                 8'(8'h41 + i));
      end
    end
  endtask

  task automatic test_random_stall();
    int unsigned a = 0, b = 0;
    logic [1:0]  m = '0;
    bit          have = 0;
    int          sent = 0;
    int          cyc = 0;
    obs_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!have && $urandom_range(0, 9) < 7) begin
        a = ($urandom_range(0, 15) == 0) ? M + $urandom_range(0, 1000) : $urandom_range(0, M - 1);
        b = $urandom_range(0, M - 1);
        m = 2'($urandom_range(0, 3));
        have = 1;
      end
      in_valid = have; in_a = DW'(a); in_b = DW'(b); in_mode = m; in_tag = 8'(sent);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, m, 8'(sent)));
        sent++;
        have = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain(1000);
    total++; if (obs_q.size() !== 1000) begin bad++; $display("FAIL rnd_count got=%0d want=1000", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].tag !== exp_q[i].tag || obs_q[i].err !== exp_q[i].err) begin
        bad++;
        $display("FAIL rnd_result[%0d] got=%0d/%0h/%b want=%0d/%0h/%b", i, obs_q[i].data, obs_q[i].tag,
                 obs_q[i].err, exp_q[i].data, exp_q[i].tag, exp_q[i].err);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    test_reset();
    test_sub_wrap();
    test_add_wrap();
    test_range_err();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
